solution_replayer: RTL and testbench
====================================

// Module: solution_replayer
// PURPOSE
//  Consumes the solver's result: packed move order (ord), move count (cnt) and completion flag (comp).
//  Replays the moves onto the start board of the 2x3 sliding puzzle and streams each board state out over a valid/ready port.
//  Checks that the final board equals GOAL and flags illegal moves.
//  Sits downstream of the register file, feeding display/checker logic.
// PARAMETERS
//  MAX_MOVES  20  maximum moves in ord (2 bits each, move k at ord[2k+1:2k])
//  CELL_W     3   bits per cell; value 0 = blank
//  NCELLS     6   cells; cell i at board[3i+2:3i]; row0 = cells 0..2, row1 = cells 3..5
//  COLS       3   grid width
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   one-cycle request to begin replay
//  sol_comp    in   1   solver completion flag; start is honoured only when 1
//  sol_cnt     in   5   number of moves, 0..MAX_MOVES
//  sol_ord     in   40  packed moves: 00 up, 01 down, 10 left, 11 right (blank's direction)
//  init_board  in   18  start board
//  goal_board  in   18  target board
//  out_valid   out  1   out_board/out_step valid
//  out_ready   in   1   sink accepts beat
//  out_board   out  18  board after out_step moves
//  out_step    out  5   0..sol_cnt
//  out_last    out  1   final beat (out_step == cnt)
//  busy        out  1   replay in progress
//  done        out  1   one-cycle pulse at end of replay
//  match       out  1   valid with done: final board == goal_board
//  err         out  1   valid with done, held until next start: illegal move, bad cnt or bad blank
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; internal board, step and blank position cleared. Reset mid-replay aborts with no done pulse.
//  - IDLE: on start & sol_comp, latch ord, cnt, init_board and goal_board; clear err; busy=1 next cycle; go to CHECK.
//    start with sol_comp=0 is ignored. start while busy is ignored.
//  - CHECK (1 cycle): locate blank by scanning cells.
//    Exactly one zero cell -> blank_pos latched; go to EMIT.
//    Zero or more than one zero cell, or cnt > MAX_MOVES -> err=1; go to DONE.
//  - EMIT: out_valid=1, out_step=step, out_last=(step==cnt). Outputs are held stable while out_valid & !out_ready.
//    On handshake with out_last -> DONE.
//    Otherwise decode move[step]:
//      up legal if pos>=3 (pos-3); down if pos<3 (pos+3);
//      left if pos%3!=0 (pos-1); right if pos%3!=2 (pos+1).
//    Legal move: swap blank with target cell, update blank_pos, step+1, stay EMIT. out_valid drops for 0 cycles (back-to-back beats allowed).
//    Illegal move: err=1; out_valid=0 next cycle; go to DONE.
//  - First out_valid appears 2 cycles after the accepted start. cnt=0 yields exactly one beat: step 0, last=1, init board.
//  - DONE (1 cycle): done=1; match=(board==goal)&!err; busy=0 next cycle; return to IDLE. match/err hold until next start.
//  - Step counter is 5 bits and never exceeds cnt, so there is no wrap-around.
// STRUCTURE
//  - puzzle_pkg: move codes (MV_UP..MV_RIGHT), CELL_W, NCELLS, COLS, board width 18, GOAL constant 18'b000_001_010_011_100_101, state encoding.
//  - Sub-module tile_mover (combinational): board, blank_pos, move -> new_board, new_pos, legal.
//  - Top module holds the FSM, latches and step counter.
// TESTING
//  1. init=18'b100_010_001_011_101_000, cnt=1, ord[1:0]=11 (right), ready=1 -> beats step0 = init; step1 = 18'b100_010_001_011_000_101, last=1; done with match=1 when goal = step1 board.
//  2. Same init, cnt=1, move 00 (up, blank at cell 0) -> one beat step0, then done=1, err=1, match=0.
//  3. cnt=0 -> single beat with step0, last=1, out_board=init; match=1 iff goal==init.
//  4. Backpressure: ready low for 3 cycles during step 2 of a 4-move replay -> out_board/out_step stable; no move is skipped; 5 beats total.
//  5. cnt=21, or init containing two zero cells -> no beats; done=1, err=1. start with sol_comp=0 -> no activity, busy stays 0.
//  6. rst_n low during step 3 -> all outputs 0 asynchronously; after release, a new start replays from step 0.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared constants, move/state encodings and cell helpers for the 2x3 puzzle replayer.
package puzzle_pkg;
  localparam int MAX_MOVES = 20;
  localparam int CELL_W    = 3;
  localparam int NCELLS    = 6;
  localparam int COLS      = 3;
  localparam int BOARD_W   = CELL_W * NCELLS;
  localparam int ORD_W     = 2 * MAX_MOVES;
  localparam int STEP_W    = 5;
  localparam int POS_W     = 3;

  localparam logic [BOARD_W-1:0] GOAL = 18'b000_001_010_011_100_101;

  // Direction is the direction the blank travels.
  typedef enum logic [1:0] {MV_UP = 2'b00, MV_DOWN = 2'b01, MV_LEFT = 2'b10, MV_RIGHT = 2'b11} move_e;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_DONE} state_e;

  // Replay job captured at start; held stable for the whole replay.
  typedef struct packed {
    logic [ORD_W-1:0]   ord;
    logic [STEP_W-1:0]  cnt;
    logic [BOARD_W-1:0] goal;
  } job_t;

  function automatic logic [POS_W-1:0] count_blanks(input logic [BOARD_W-1:0] b);
    logic [POS_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCELLS; i++)
      if (b[i*CELL_W +: CELL_W] == '0) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [POS_W-1:0] blank_index(input logic [BOARD_W-1:0] b);
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NCELLS; i++)
      if (b[i*CELL_W +: CELL_W] == '0) idx = POS_W'(i);
    return idx;
  endfunction

  function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [POS_W-1:0] idx);
    logic [CELL_W-1:0] c;
    c = '0;
    for (int i = 0; i < NCELLS; i++)
      if (idx == POS_W'(i)) c = b[i*CELL_W +: CELL_W];
    return c;
  endfunction

  // Mux move k out of the packed order; steps past MAX_MOVES-1 read as MV_UP.
  function automatic move_e move_at(input logic [ORD_W-1:0] ord, input logic [STEP_W-1:0] step);
    move_e m;
    m = MV_UP;
    for (int k = 0; k < MAX_MOVES; k++)
      if (step == STEP_W'(k)) m = move_e'(ord[2*k +: 2]);
    return m;
  endfunction
endpackage

// File: rtl/tile_mover.sv
// Combinational single-move engine: checks legality and swaps the blank with its neighbour.
module tile_mover
  import puzzle_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [POS_W-1:0]   blank_pos,
  input  move_e              move,
  output logic [BOARD_W-1:0] new_board,
  output logic [POS_W-1:0]   new_pos,
  output logic               legal
);
  logic [CELL_W-1:0] tgt_cell;

  // Target position and legality from the blank's row/column on the 2x3 grid
  always_comb begin
    legal   = 1'b0;
    new_pos = blank_pos;
    unique case (move)
      MV_UP:    if (blank_pos >= 3'd3) begin legal = 1'b1; new_pos = blank_pos - 3'd3; end
      MV_DOWN:  if (blank_pos <  3'd3) begin legal = 1'b1; new_pos = blank_pos + 3'd3; end
      MV_LEFT:  if (blank_pos != 3'd0 && blank_pos != 3'd3) begin legal = 1'b1; new_pos = blank_pos - 3'd1; end
      MV_RIGHT: if (blank_pos != 3'd2 && blank_pos != 3'd5) begin legal = 1'b1; new_pos = blank_pos + 3'd1; end
      default: ;
    endcase
  end

  assign tgt_cell = cell_at(board, new_pos);

  // Per-cell swap: target becomes blank, old blank takes the target's tile
  for (genvar i = 0; i < NCELLS; i++) begin : g_cell
    assign new_board[i*CELL_W +: CELL_W] =
        !legal                     ? board[i*CELL_W +: CELL_W] :
        (new_pos   == POS_W'(i))   ? '0 :
        (blank_pos == POS_W'(i))   ? tgt_cell :
                                     board[i*CELL_W +: CELL_W];
  end
endmodule

// File: rtl/solution_replayer.sv
// Replays a solver's move list onto the start board, streaming every board state out.
module solution_replayer
  import puzzle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sol_comp,
  input  logic [4:0]         sol_cnt,
  input  logic [39:0]        sol_ord,
  input  logic [17:0]        init_board,
  input  logic [17:0]        goal_board,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [17:0]        out_board,
  output logic [4:0]         out_step,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic               err
);
  state_e             state;
  job_t               job_q;
  logic [BOARD_W-1:0] board_q;
  logic [POS_W-1:0]   pos_q;
  logic [STEP_W-1:0]  step_q;

  logic [BOARD_W-1:0] nxt_board;
  logic [POS_W-1:0]   nxt_pos;
  logic               legal;

  tile_mover u_mover (
    .board     (board_q),
    .blank_pos (pos_q),
    .move      (move_at(job_q.ord, step_q)),
    .new_board (nxt_board),
    .new_pos   (nxt_pos),
    .legal     (legal)
  );

  assign out_board = board_q;
  assign out_step  = step_q;

  // Replay FSM: latch job, validate board/count, emit beats with moves applied, report result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      job_q     <= '0;
      board_q   <= '0;
      pos_q     <= '0;
      step_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start && sol_comp) begin
          job_q   <= '{ord: sol_ord, cnt: sol_cnt, goal: goal_board};
          board_q <= init_board;
          pos_q   <= '0;
          step_q  <= '0;
          err     <= 1'b0;
          match   <= 1'b0;
          busy    <= 1'b1;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (count_blanks(board_q) != 3'd1 || job_q.cnt > STEP_W'(MAX_MOVES)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            pos_q     <= blank_index(board_q);
            out_valid <= 1'b1;
            out_last  <= (job_q.cnt == '0);
            state     <= S_EMIT;
          end
        end
        S_EMIT: if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            match     <= (board_q == job_q.goal);
            state     <= S_DONE;
          end else if (legal) begin
            board_q  <= nxt_board;
            pos_q    <= nxt_pos;
            step_q   <= step_q + 5'd1;
            out_last <= (step_q + 5'd1 == job_q.cnt);
          end else begin
            err       <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_solution_replayer.sv
// Randomized bench for solution_replayer with a cell-array puzzle model and per-cycle stream checker.
module tb_solution_replayer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sol_comp = 1'b0;
  logic [4:0]  sol_cnt = '0;
  logic [39:0] sol_ord = '0;
  logic [17:0] init_board = '0, goal_board = '0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_last, busy, done, match, err;
  logic [17:0] out_board;
  logic [4:0]  out_step;

  solution_replayer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sol_comp(sol_comp), .sol_cnt(sol_cnt),
    .sol_ord(sol_ord), .init_board(init_board), .goal_board(goal_board),
    .out_valid(out_valid), .out_ready(out_ready), .out_board(out_board), .out_step(out_step),
    .out_last(out_last), .busy(busy), .done(done), .match(match), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- expectation state produced by the model ----
  logic [17:0] exp_beats [0:20];
  int          exp_n = 0, exp_cnt = 0, run_id = 0;
  logic        exp_err = 1'b0, exp_match = 1'b0;
  logic        chk_en = 1'b0;

  // Puzzle model on row/column coordinates; fills the expected beat list
  task automatic model(input logic [17:0] init, input logic [17:0] goal, input int cnt, input logic [39:0] ord);
    logic [17:0] b;
    int zeros, pos, row, col, tgt;
    logic ok;
    zeros = 0; pos = 0; b = init;
    for (int i = 0; i < 6; i++) if (init[3*i +: 3] == 3'd0) begin zeros++; pos = i; end
    exp_cnt = cnt;
    if (cnt > 20 || zeros != 1) begin
      exp_err = 1'b1; exp_n = 0; exp_match = 1'b0; return;
    end
    exp_beats[0] = init;
    for (int k = 0; k < cnt; k++) begin
      row = pos / 3; col = pos % 3;
      case (ord[2*k +: 2])
        2'd0: begin ok = (row == 1); tgt = pos - 3; end
        2'd1: begin ok = (row == 0); tgt = pos + 3; end
        2'd2: begin ok = (col > 0);  tgt = pos - 1; end
        default: begin ok = (col < 2); tgt = pos + 1; end
      endcase
      if (!ok) begin
        exp_err = 1'b1; exp_n = k + 1; exp_match = 1'b0; return;
      end
      b[3*pos +: 3] = b[3*tgt +: 3];
      b[3*tgt +: 3] = 3'd0;
      pos = tgt;
      exp_beats[k+1] = b;
    end
    exp_n = cnt + 1; exp_err = 1'b0; exp_match = (b == goal);
  endtask

  // ---- sink ready generator: 1 = always, 0 = random, 2 = 3-cycle stall at step 2 ----
  int rdy_mode = 1;
  int hold = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = 1'b1;
    else if (rdy_mode == 0) out_ready = ($urandom_range(3) != 0);
    else begin
      if (out_valid && out_step == 5'd2 && hold < 3) begin out_ready = 1'b0; hold++; end
      else begin out_ready = 1'b1; if (out_step != 5'd2) hold = 0; end
    end
  end

  // ---- stream checker: every beat, stall stability, result at done ----
  int          bidx = 0, seen_run = 0;
  logic        pstall = 1'b0, plast = 1'b0;
  logic [17:0] pboard = '0;
  logic [4:0]  pstep = '0;
  always @(negedge clk) begin
    if (!rst_n || !chk_en) pstall = 1'b0;
    else begin
      if (run_id != seen_run) begin seen_run = run_id; bidx = 0; end
      if (pstall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_board", out_board, pboard);
        chk("stall_step", out_step, pstep);
        chk("stall_last", out_last, plast);
      end
      if (out_valid) begin
        chk("beat_in_range", (bidx < exp_n), 1);
        if (bidx < exp_n) begin
          chk("beat_board", out_board, exp_beats[bidx]);
          chk("beat_step", out_step, bidx);
          chk("beat_last", out_last, (bidx == exp_cnt));
        end
        pstall = !out_ready; pboard = out_board; pstep = out_step; plast = out_last;
        if (out_ready) bidx++;
      end else pstall = 1'b0;
      if (done) begin
        chk("done_err", err, exp_err);
        chk("done_match", match, exp_match);
        chk("beat_count", bidx, exp_n);
      end
    end
  end

  // One replay: accepted start, an ignored start while busy with scrambled inputs, wait for done
  task automatic run(input logic [17:0] init, input logic [17:0] goal, input int cnt, input logic [39:0] ord);
    model(init, goal, cnt, ord);
    run_id++;
    init_board = init; goal_board = goal; sol_cnt = 5'(cnt); sol_ord = ord;
    sol_comp = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    init_board = 18'($urandom); goal_board = 18'($urandom);
    sol_cnt = 5'($urandom); sol_ord = {8'($urandom), 32'($urandom)};
    @(negedge clk);
    chk("lat0_busy", busy, 1);
    chk("lat0_valid", out_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat1_valid", out_valid, (exp_n > 0));
    for (int c = 0; c < 400; c++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_clear", busy, 0);
    @(negedge clk);
    chk("err_hold", err, exp_err);
    chk("match_hold", match, exp_match);
    @(posedge clk); #1;
  endtask

  function automatic logic [17:0] rand_perm();
    int v [6];
    int j, t;
    logic [17:0] b;
    for (int i = 0; i < 6; i++) v[i] = i;
    for (int i = 5; i > 0; i--) begin
      j = $urandom_range(i); t = v[i]; v[i] = v[j]; v[j] = t;
    end
    for (int i = 0; i < 6; i++) b[3*i +: 3] = 3'(v[i]);
    return b;
  endfunction

  // Random walk of mostly legal moves from the board's blank; trailing bits left random
  function automatic logic [39:0] gen_walk(input logic [17:0] init, input int cnt, input int bad_pct);
    logic [39:0] ord;
    int pos, d, row, col;
    int legal_d [$];
    ord = {8'($urandom), 32'($urandom)};
    pos = 0;
    for (int i = 0; i < 6; i++) if (init[3*i +: 3] == 3'd0) pos = i;
    for (int k = 0; k < cnt && k < 20; k++) begin
      row = pos / 3; col = pos % 3;
      legal_d.delete();
      if (row == 1) legal_d.push_back(0);
      if (row == 0) legal_d.push_back(1);
      if (col > 0)  legal_d.push_back(2);
      if (col < 2)  legal_d.push_back(3);
      if (int'($urandom_range(99)) < bad_pct) d = $urandom_range(3);
      else d = legal_d[$urandom_range(legal_d.size() - 1)];
      ord[2*k +: 2] = 2'(d);
      case (d)
        0: if (row == 1) pos -= 3;
        1: if (row == 0) pos += 3;
        2: if (col > 0)  pos -= 1;
        default: if (col < 2) pos += 1;
      endcase
    end
    return ord;
  endfunction

  localparam logic [17:0] T1   = 18'b100_010_001_011_101_000;
  localparam logic [17:0] GOALB = 18'b000_001_010_011_100_101;

  initial begin
    logic [17:0] ib, gb;
    logic [39:0] ob;
    int cn;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_match", match, 0); chk("rst_board", out_board, 0);
    chk("rst_step", out_step, 0); chk("rst_last", out_last, 0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // 1: one legal right move reaching the goal
    run(T1, 18'b100_010_001_011_000_101, 1, 40'h3);
    chk("pin1_beat1", exp_beats[1], 18'b100_010_001_011_000_101);
    chk("pin1_n", exp_n, 2);
    chk("pin1_match", exp_match, 1);

    // 2: illegal up from cell 0
    run(T1, T1, 1, 40'h0);
    chk("pin2_err", exp_err, 1);
    chk("pin2_n", exp_n, 1);

    // 3: zero moves, goal equal / not equal to init
    run(T1, T1, 0, 40'hFF);
    chk("pin3_match", exp_match, 1);
    run(T1, GOALB, 0, 40'h0);
    chk("pin3b_match", exp_match, 0);

    // 4: four moves with a 3-cycle stall at step 2
    rdy_mode = 2;
    run(T1, 18'b100_001_101_011_010_000, 4, 40'h27);
    chk("pin4_n", exp_n, 5);
    chk("pin4_final", exp_beats[4], 18'b100_001_101_011_010_000);
    chk("pin4_match", exp_match, 1);
    rdy_mode = 1;

    // 5: bad count, two blanks, start without completion
    run(T1, T1, 21, 40'h0);
    chk("pin5_n", exp_n, 0);
    run(18'b000_010_001_011_101_000, T1, 1, 40'h3);
    chk("pin5b_err", exp_err, 1);
    init_board = T1; sol_cnt = 5'd1; sol_ord = 40'h3; sol_comp = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("nocomp_busy", busy, 0);
      chk("nocomp_valid", out_valid, 0);
    end
    @(posedge clk); #1;

    // 6: reset during step 3, then a clean replay
    model(T1, T1, 4, 40'h27);
    run_id++;
    init_board = T1; goal_board = T1; sol_cnt = 5'd4; sol_ord = 40'h27; sol_comp = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid && out_step == 5'd3) break;
    end
    chk("reach_step3", out_step, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_step", out_step, 0); chk("arst_board", out_board, 0); chk("arst_last", out_last, 0);
    chk("arst_err", err, 0); chk("arst_match", match, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(T1, 18'b100_001_101_011_010_000, 4, 40'h27);

    // random replays with random backpressure
    rdy_mode = 0;
    for (int r = 0; r < 60; r++) begin
      ib = ($urandom_range(99) < 85) ? rand_perm() : 18'($urandom);
      cn = ($urandom_range(99) < 90) ? int'($urandom_range(20)) : int'($urandom_range(31, 21));
      ob = gen_walk(ib, cn, 8);
      model(ib, 18'h0, cn, ob);
      case ($urandom_range(4))
        0, 1:    gb = (!exp_err && exp_n > 0) ? exp_beats[exp_n-1] : rand_perm();
        2:       gb = GOALB;
        default: gb = rand_perm();
      endcase
      run(ib, gb, cn, ob);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
